// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// FSM encoding, add-3 correction constants and default digit widths.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_ADDEND = 4'd3;

  localparam int WIDTH_DEF  = 9;
  localparam int DIGITS_DEF = 3;
  localparam int BCD_W      = 4 * DIGITS_DEF;

  // Used at elaboration to prove DIGITS can hold the largest input.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
// Input is always <= 9, so the 4-bit result never exceeds 12.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + ADD3_ADDEND : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// bcd is only written on the final step, so it never shows partial values.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int OUT_W = 4 * DIGITS;
  localparam int SR_W  = OUT_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t                   state, state_n;
  logic [SR_W-1:0]          sreg, sreg_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [OUT_W-1:0]         bcd_n;
  logic                     done_n;

  logic [DIGITS-1:0][3:0]   adj;
  logic [SR_W-1:0]          corrected;
  logic [SR_W-1:0]          shifted;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (sreg[WIDTH + 4*d +: 4]),
      .dout (adj[d])
    );
  end

  assign corrected = {adj, sreg[WIDTH-1:0]};
  assign shifted   = {corrected[SR_W-2:0], 1'b0};
  assign busy      = (state == SHIFT);

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    bcd_n   = bcd;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_n  = {{OUT_W{1'b0}}, bin};
          cnt_n   = CNT_W'(WIDTH);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sreg_n = shifted;
        cnt_n  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          bcd_n   = shifted[SR_W-1 -: OUT_W];
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      bcd   <= bcd_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected digits queued at start,
// observed digits queued on each done pulse, compared inside each test task.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_run = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  bin2bcd_seq #(.WIDTH(9), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // One clock; outputs sampled 1ns after the edge, done pulses logged.
  task automatic step();
    @(posedge clk);
    #1;
    if (busy) busy_run++;
    if (done) begin
      done_seen++;
      obs_q.push_back(bcd);
    end
  endtask

  task automatic start_conv(input int v);
    bin   = 9'(v);
    start = 1'b1;
    busy_run = 0;
    step();
    start = 1'b0;
    exp_q.push_back(ref_bcd(v));
  endtask

  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int d0;
    rst = 1'b1; start = 1'b0; bin = '0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    d0 = done_seen;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (done_seen != d0) begin errors++; $display("FAIL idle_done got %0d pulses want 0", done_seen - d0); end
  endtask

  task automatic test_max_and_zero();
    int lat; bit to;
    logic [11:0] e, o;
    int vals[2] = '{511, 0};
    logic [11:0] lits[2] = '{12'h511, 12'h000};
    for (int k = 0; k < 2; k++) begin
      start_conv(vals[k]);
      wait_done(lat, to);
      checks++;
      if (to || lat != 9) begin errors++; $display("FAIL latency_%0d got %0d timeout=%0b want 9", vals[k], lat, to); end
      checks++;
      if (busy_run != 9) begin errors++; $display("FAIL busy_cycles_%0d got %0d want 9", vals[k], busy_run); end
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e || o !== lits[k]) begin errors++; $display("FAIL value_%0d got %h want %h", vals[k], o, lits[k]); end
      step();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_width_%0d got %b want 0", vals[k], done); end
    end
  endtask

  task automatic test_boundaries();
    int lat; bit to;
    logic [11:0] e, o;
    int vals[4] = '{99, 100, 255, 256};
    logic [11:0] lits[4] = '{12'h099, 12'h100, 12'h255, 12'h256};
    for (int k = 0; k < 4; k++) begin
      start_conv(vals[k]);
      wait_done(lat, to);
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (to || o !== e || o !== lits[k]) begin
        errors++; $display("FAIL boundary_%0d got %h want %h", vals[k], o, lits[k]);
      end
    end
  endtask

  task automatic test_sweep();
    int lat; bit to;
    logic [11:0] e, o;
    for (int v = 0; v < 512; v++) begin
      start_conv(v);
      wait_done(lat, to);
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (to || lat != 9 || o !== e) begin
        errors++; $display("FAIL sweep_%0d got %h lat %0d want %h lat 9", v, o, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; int d0;
    logic [11:0] e, o;
    d0 = done_seen;
    start_conv(123);
    step(); step(); step();
    bin = 9'd456; start = 1'b1;
    step();
    start = 1'b0; bin = 9'd0;
    wait_done(lat, to);
    checks++;
    if (to || lat != 5) begin errors++; $display("FAIL busy_ignore_lat got %0d timeout=%0b want 5", lat, to); end
    // accept on the done cycle
    start_conv(456);
    wait_done(lat, to);
    checks++;
    if (to || lat != 9) begin errors++; $display("FAIL b2b_lat got %0d timeout=%0b want 9", lat, to); end
    step();
    checks++;
    if (done_seen - d0 != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", done_seen - d0); end
    for (int k = 0; k < 2; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e || o !== (k == 0 ? 12'h123 : 12'h456)) begin
        errors++; $display("FAIL b2b_value_%0d got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit to; int d0;
    logic [11:0] e, o;
    d0 = done_seen;
    start_conv(300);
    void'(exp_q.pop_back());
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || bcd !== 12'h000) begin
      errors++; $display("FAIL abort_state got busy=%b bcd=%h want busy=0 bcd=000", busy, bcd);
    end
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (done_seen != d0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_seen - d0); end
    start_conv(42);
    wait_done(lat, to);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
    checks++;
    if (to || o !== e || o !== 12'h042) begin errors++; $display("FAIL after_abort got %h want 042", o); end
  endtask

  task automatic test_bin_change();
    int lat; bit to;
    logic [11:0] e, o;
    start_conv(77);
    bin = 9'd500;
    wait_done(lat, to);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
    checks++;
    if (to || o !== e || o !== 12'h077) begin errors++; $display("FAIL bin_change got %h want 077", o); end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (bcd !== 12'h077) begin errors++; $display("FAIL bcd_hold got %h want 077", bcd); end
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got obs=%0d exp=%0d want 0", obs_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_max_and_zero();
    test_boundaries();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    test_bin_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
